pacman_sprite_fetch: RTL and testbench

Upstream pixel-fetch stage for the yellow Pac-Man palette lookup. For every pixel the VGA controller is drawing, the block decides whether that pixel falls inside the Pac-Man sprite box. It then forms the address into the external sprite index ROM, applying the current animation frame and the facing direction. Finally it returns the 5-bit palette index, plus a sprite-hit flag, aligned in a fixed pipeline. The index output feeds the yellow palette directly, and the hit flag feeds the colour mapper's layer select.

---
 rtl/pacman_pkg.sv | 21 ++
 rtl/pacman_sprite_fetch_anim_sequencer.sv | 62 ++++++
 rtl/pacman_sprite_fetch.sv | 102 ++++++++++
 tb/tb_pacman_sprite_fetch.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man sprite fetch path.
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  typedef enum logic {
    ANIM_ASC  = 1'b0,
    ANIM_DESC = 1'b1
  } anim_dir_t;

  localparam int SPRITE_SIZE_DEF = 16;
  localparam int FRAMES_DEF      = 4;

  localparam logic [4:0] PAL_TRANSPARENT = 5'd0;

endpackage

// File: rtl/pacman_sprite_fetch_anim_sequencer.sv
// Mouth animation: divides frame_tick by ANIM_DIV and ping-pongs the frame number.
//   state     | meaning
//   ANIM_ASC  | frame counts up on each step, turns around at FRAMES-1
//   ANIM_DESC | frame counts down on each step, turns around at 0
module anim_sequencer
  import pacman_pkg::*;
#(
  parameter int FRAMES   = FRAMES_DEF,
  parameter int ANIM_DIV = 6,
  parameter int FRAME_W  = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               pac_moving,
  output logic [FRAME_W-1:0] frame
);

  localparam int DIV_W = $clog2(ANIM_DIV + 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(ANIM_DIV - 1);

  anim_dir_t        state;
  logic [DIV_W-1:0] divider;

  // A stationary Pac-Man restarts the divider so motion always begins with a full step.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= ANIM_ASC;
      divider <= '0;
      frame   <= '0;
    end else if (!pac_moving) begin
      divider <= '0;
    end else if (frame_tick) begin
      if (divider == DIV_LAST) begin
        divider <= '0;
        case (state)
          ANIM_ASC: begin
            if (frame == LAST_FRAME) begin
              frame <= frame - FRAME_W'(1);
              state <= ANIM_DESC;
            end else begin
              frame <= frame + FRAME_W'(1);
            end
          end
          ANIM_DESC: begin
            if (frame == '0) begin
              frame <= frame + FRAME_W'(1);
              state <= ANIM_ASC;
            end else begin
              frame <= frame - FRAME_W'(1);
            end
          end
          default: state <= ANIM_ASC;
        endcase
      end else begin
        divider <= divider + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/pacman_sprite_fetch.sv
// Pac-Man sprite fetch: box test, orientation transform and ROM address,
// returning the palette index and hit flag three clocks after DrawX/DrawY.
module pacman_sprite_fetch
  import pacman_pkg::*;
#(
  parameter int SPRITE_SIZE = SPRITE_SIZE_DEF,
  parameter int FRAMES      = FRAMES_DEF,
  parameter int ANIM_DIV    = 6,
  parameter int ADDR_W      = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        pac_x,
  input  logic [9:0]        pac_y,
  input  logic [1:0]        pac_dir,
  input  logic              pac_moving,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [4:0]        rom_data,
  output logic [4:0]        index,
  output logic              sprite_on
);

  localparam int LOG2_S  = $clog2(SPRITE_SIZE);
  localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  logic [9:0]         shadow_x, shadow_y;
  dir_t               shadow_dir;
  logic [FRAME_W-1:0] frame;
  logic [10:0]        dx, dy;
  logic [LOG2_S-1:0]  dx_l, dy_l, row, col;
  logic               in_box, in_box_q1, in_box_q2;
  logic [ADDR_W-1:0]  addr_next;

  anim_sequencer #(
    .FRAMES   (FRAMES),
    .ANIM_DIV (ANIM_DIV),
    .FRAME_W  (FRAME_W)
  ) u_anim (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .pac_moving (pac_moving),
    .frame      (frame)
  );

  // Position and facing only move at frame boundaries to avoid tearing.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shadow_x   <= '0;
      shadow_y   <= '0;
      shadow_dir <= DIR_RIGHT;
    end else if (frame_tick) begin
      shadow_x   <= pac_x;
      shadow_y   <= pac_y;
      shadow_dir <= dir_t'(pac_dir);
    end
  end

  // Unsigned wrap pushes pixels left of or above the sprite out of range.
  assign dx     = {1'b0, DrawX} - {1'b0, shadow_x};
  assign dy     = {1'b0, DrawY} - {1'b0, shadow_y};
  assign in_box = (dx < 11'(SPRITE_SIZE)) && (dy < 11'(SPRITE_SIZE));
  assign dx_l   = dx[LOG2_S-1:0];
  assign dy_l   = dy[LOG2_S-1:0];

  // The stored artwork faces right; ~dx_l is S-1-dx for a power-of-two edge.
  always_comb begin
    row = dy_l;
    col = dx_l;
    case (shadow_dir)
      DIR_RIGHT: begin row = dy_l;  col = dx_l;  end
      DIR_LEFT:  begin row = dy_l;  col = ~dx_l; end
      DIR_DOWN:  begin row = dx_l;  col = dy_l;  end
      DIR_UP:    begin row = ~dx_l; col = dy_l;  end
      default:   begin row = dy_l;  col = dx_l;  end
    endcase
  end

  assign addr_next = ADDR_W'(frame) * ADDR_W'(SPRITE_SIZE * SPRITE_SIZE)
                   + ADDR_W'(row) * ADDR_W'(SPRITE_SIZE)
                   + ADDR_W'(col);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr  <= '0;
      in_box_q1 <= 1'b0;
      in_box_q2 <= 1'b0;
      index     <= PAL_TRANSPARENT;
      sprite_on <= 1'b0;
    end else begin
      rom_addr  <= addr_next;
      in_box_q1 <= in_box;
      in_box_q2 <= in_box_q1;
      sprite_on <= in_box_q2 && (rom_data != PAL_TRANSPARENT);
      index     <= (in_box_q2 && (rom_data != PAL_TRANSPARENT)) ? rom_data : PAL_TRANSPARENT;
    end
  end

endmodule

// File: tb/tb_pacman_sprite_fetch.sv
// Self-checking bench for pacman_sprite_fetch against a behavioural sprite model.
module tb_pacman_sprite_fetch;
  import pacman_pkg::*;

  localparam int S        = 16;
  localparam int ANIM_DIV = 6;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       pac_moving = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, pac_x = '0, pac_y = '0;
  logic [1:0] pac_dir = '0;
  logic [9:0] rom_addr;
  logic [4:0] rom_data = '0;
  logic [4:0] index;
  logic       sprite_on;

  int tests = 0;
  int fails = 0;
  int zero_addr = -1;

  // Model state: latched position/direction, completed animation steps, tick count within step
  int m_sx = 0, m_sy = 0, m_dir = 0, m_steps = 0, m_div = 0;
  int seq [6] = '{0, 1, 2, 3, 2, 1};

  pacman_sprite_fetch dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .pac_x      (pac_x),
    .pac_y      (pac_y),
    .pac_dir    (pac_dir),
    .pac_moving (pac_moving),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .index      (index),
    .sprite_on  (sprite_on)
  );

  always #5 Clk = ~Clk;

  function automatic int rom_val(int a);
    if (a == zero_addr) return 0;
    return ((a * 13 + 5) % 31) + 1;
  endfunction

  always @(posedge Clk) rom_data <= 5'(rom_val(int'(rom_addr)));

  function automatic int m_frame();
    return seq[m_steps % 6];
  endfunction

  function automatic int exp_addr(int x, int y);
    int dx, dy, row, col;
    dx = (x - m_sx) & (S - 1);
    dy = (y - m_sy) & (S - 1);
    case (m_dir)
      0:       begin row = dy;         col = dx;         end
      1:       begin row = dy;         col = S - 1 - dx; end
      2:       begin row = S - 1 - dx; col = dy;         end
      default: begin row = dx;         col = dy;         end
    endcase
    return m_frame() * S * S + row * S + col;
  endfunction

  function automatic bit exp_in(int x, int y);
    int dx, dy;
    dx = x - m_sx;
    dy = y - m_sy;
    return (dx >= 0) && (dx < S) && (dy >= 0) && (dy < S);
  endfunction

  function automatic int exp_idx(int x, int y);
    if (!exp_in(x, y)) return 0;
    return rom_val(exp_addr(x, y));
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick(bit mv);
    pac_moving = mv;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    m_sx = int'(pac_x);
    m_sy = int'(pac_y);
    m_dir = int'(pac_dir);
    if (mv) begin
      m_div++;
      if (m_div == ANIM_DIV) begin
        m_div = 0;
        m_steps++;
      end
    end else begin
      m_div = 0;
    end
  endtask

  task automatic test_reset();
    int ei;
    step();
    tests++;
    if (index !== 5'd0 || sprite_on !== 1'b0 || rom_addr !== 10'd0) begin
      fails++;
      $display("FAIL reset_hold: index=%0d sprite_on=%0b rom_addr=%0d, required all 0", index, sprite_on, rom_addr);
    end
    Reset = 1'b0;
    DrawX = 10'd3; DrawY = 10'd2;
    step(); step(); step();
    tests++;
    if (sprite_on !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_hit: sprite_on=%0b, required 1", sprite_on);
    end
    Reset = 1'b1;
    #1;
    tests++;
    if (index !== 5'd0 || sprite_on !== 1'b0 || rom_addr !== 10'd0) begin
      fails++;
      $display("FAIL reset_async: index=%0d sprite_on=%0b rom_addr=%0d, required all 0", index, sprite_on, rom_addr);
    end
    step();
    pac_x = 10'd50;
    Reset = 1'b0;
    step();
    tests++;
    if (rom_addr !== 10'd35) begin
      fails++;
      $display("FAIL reset_addr: rom_addr=%0d, required 35", rom_addr);
    end
    step();
    tests++;
    if (sprite_on !== 1'b0) begin
      fails++;
      $display("FAIL reset_latency: sprite_on=%0b at N+2, required 0", sprite_on);
    end
    step();
    ei = rom_val(35);
    tests++;
    if (sprite_on !== 1'b1 || index !== 5'(ei)) begin
      fails++;
      $display("FAIL reset_first_out: index=%0d sprite_on=%0b, required %0d/1", index, sprite_on, ei);
    end
    pac_x = 10'd0;
  endtask

  task automatic test_box_edges();
    int xs [5] = '{99, 115, 116, 100, 105};
    int ys [5] = '{55, 55, 55, 50, 49};
    int ea, ei;
    pac_x = 10'd100; pac_y = 10'd50; pac_dir = 2'd0;
    tick(1'b0);
    for (int i = 0; i < 5; i++) begin
      DrawX = 10'(xs[i]); DrawY = 10'(ys[i]);
      ea = exp_addr(xs[i], ys[i]);
      step();
      tests++;
      if (rom_addr !== 10'(ea)) begin
        fails++;
        $display("FAIL box_addr[%0d]: rom_addr=%0d, required %0d", i, rom_addr, ea);
      end
      step(); step();
      ei = exp_idx(xs[i], ys[i]);
      tests++;
      if (sprite_on !== (ei != 0) || index !== 5'(ei)) begin
        fails++;
        $display("FAIL box_edge[%0d]: index=%0d sprite_on=%0b, required %0d/%0b", i, index, sprite_on, ei, ei != 0);
      end
    end
  endtask

  task automatic test_orientation();
    int req [4] = '{82, 93, 213, 37};
    pac_x = 10'd200; pac_y = 10'd100;
    DrawX = 10'd202; DrawY = 10'd105;
    for (int d = 0; d < 4; d++) begin
      pac_dir = 2'(d);
      tick(1'b0);
      step();
      tests++;
      if (rom_addr !== 10'(req[d])) begin
        fails++;
        $display("FAIL orient[%0d]: rom_addr=%0d, required %0d", d, rom_addr, req[d]);
      end
    end
  endtask

  task automatic test_animation();
    int ea;
    pac_dir = 2'd0;
    DrawX = pac_x; DrawY = pac_y;
    tick(1'b0);
    for (int i = 0; i < 36 + 3 + 1 + 6; i++) begin
      tick(!(i == 39));
      if (i > 39) pac_moving = 1'b1;
      step();
      ea = m_frame() * S * S;
      tests++;
      if (rom_addr !== 10'(ea)) begin
        fails++;
        $display("FAIL anim_frame[%0d]: rom_addr=%0d, required %0d", i, rom_addr, ea);
      end
      if (i == 35) begin
        tests++;
        if (rom_addr !== 10'd0) begin
          fails++;
          $display("FAIL anim_wrap: rom_addr=%0d after 36 ticks, required 0", rom_addr);
        end
      end
    end
    pac_moving = 1'b0;
    m_div = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      step();
      ea = m_frame() * S * S;
      tests++;
      if (rom_addr !== 10'(ea)) begin
        fails++;
        $display("FAIL anim_hold[%0d]: rom_addr=%0d, required %0d", i, rom_addr, ea);
      end
    end
  endtask

  task automatic test_transparency();
    int xs [3] = '{304, 305, 306};
    int ei;
    pac_x = 10'd300; pac_y = 10'd200; pac_dir = 2'd0;
    tick(1'b0);
    zero_addr = exp_addr(305, 207);
    for (int i = 0; i < 3; i++) begin
      DrawX = 10'(xs[i]); DrawY = 10'd207;
      step(); step(); step();
      ei = exp_idx(xs[i], 207);
      tests++;
      if (sprite_on !== (ei != 0) || index !== 5'(ei)) begin
        fails++;
        $display("FAIL transparent[%0d]: index=%0d sprite_on=%0b, required %0d/%0b", i, index, sprite_on, ei, ei != 0);
      end
    end
    zero_addr = -1;
  endtask

  task automatic test_tearing();
    int old_a, new_a;
    DrawX = 10'd305; DrawY = 10'd207;
    pac_x = 10'd298;
    old_a = exp_addr(305, 207);
    step(); step();
    tests++;
    if (rom_addr !== 10'(old_a)) begin
      fails++;
      $display("FAIL tear_mid_frame: rom_addr=%0d, required %0d", rom_addr, old_a);
    end
    tick(1'b0);
    tests++;
    if (rom_addr !== 10'(old_a)) begin
      fails++;
      $display("FAIL tear_tick_edge: rom_addr=%0d, required %0d", rom_addr, old_a);
    end
    new_a = exp_addr(305, 207);
    step();
    tests++;
    if (rom_addr !== 10'(new_a)) begin
      fails++;
      $display("FAIL tear_after_tick: rom_addr=%0d, required %0d", rom_addr, new_a);
    end
  endtask

  task automatic test_random();
    int x, y, ea, ei;
    for (int it = 0; it < 25; it++) begin
      pac_x = 10'($urandom_range(4, 1000));
      pac_y = 10'($urandom_range(4, 1000));
      pac_dir = 2'($urandom_range(0, 3));
      tick(1'($urandom_range(0, 1)));
      for (int p = 0; p < 3; p++) begin
        x = int'(pac_x) + int'($urandom_range(0, S + 7)) - 4;
        y = int'(pac_y) + int'($urandom_range(0, S + 7)) - 4;
        DrawX = 10'(x); DrawY = 10'(y);
        ea = exp_addr(x, y);
        step();
        tests++;
        if (rom_addr !== 10'(ea)) begin
          fails++;
          $display("FAIL rand_addr[%0d.%0d]: rom_addr=%0d, required %0d", it, p, rom_addr, ea);
        end
        step(); step();
        ei = exp_idx(x, y);
        tests++;
        if (sprite_on !== (ei != 0) || index !== 5'(ei)) begin
          fails++;
          $display("FAIL rand_pix[%0d.%0d]: index=%0d sprite_on=%0b, required %0d/%0b", it, p, index, sprite_on, ei, ei != 0);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int q [$];
    int x, y, ei;
    localparam int N = 40;
    pac_x = 10'd400; pac_y = 10'd300; pac_dir = 2'($urandom_range(0, 3));
    tick(1'b0);
    for (int i = 0; i < N + 2; i++) begin
      if (i < N) begin
        x = 400 + int'($urandom_range(0, S + 3)) - 2;
        y = 300 + int'($urandom_range(0, S + 3)) - 2;
        DrawX = 10'(x); DrawY = 10'(y);
        q.push_back(exp_idx(x, y));
      end
      step();
      if (i >= 2) begin
        ei = q.pop_front();
        tests++;
        if (sprite_on !== (ei != 0) || index !== 5'(ei)) begin
          fails++;
          $display("FAIL b2b[%0d]: index=%0d sprite_on=%0b, required %0d/%0b", i - 2, index, sprite_on, ei, ei != 0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_box_edges();
    test_orientation();
    test_animation();
    test_transparency();
    test_tearing();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
